// File: rtl/tilemap_column_writer.sv
// tilemap_column_writer
// Streams level columns into a 32-column tilemap ring ahead of the visible
// window and owns the horizontal scroll position.
// Optional feature macro: TILEMAP_WRITER_STALL_EN (an illegal scroll advance
// stalls the scroll instead of advancing into stale columns).
//
// Column stream handshake: a beat transfers on a rising clk edge where
// col_valid and col_ready are both high; col_tile/col_last are sampled on
// that edge. col_ready never depends on col_valid.
module tilemap_column_writer #(
  parameter int LOOKAHEAD = 24,
  parameter int ROWS      = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_tick,
  input  logic [4:0]  speed,
  input  logic        col_valid,
  output logic        col_ready,
  input  logic [7:0]  col_tile,
  input  logic        col_last,
  output logic [13:0] tm_address,
  output logic        tm_we,
  output logic [7:0]  tm_din,
  output logic [9:0]  scroll_offset,
  output logic [4:0]  ahead,
  output logic        underrun
);

  localparam logic [4:0] LOOKAHEAD_C = 5'(LOOKAHEAD);
  localparam logic [3:0] LAST_ROW    = 4'(ROWS - 1);
  localparam logic [4:0] MIN_AHEAD   = 5'd21;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PAD    = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  write_col;
  logic [3:0]  row;
  logic [3:0]  row_next;
  logic        wr_en;
  logic [7:0]  wr_tile;
  logic        col_advance;

  logic [4:0]  wc_after;
  logic [9:0]  scroll_next;
  logic [4:0]  ahead_after;
  logic        advance_ok;

  // Distance from the scroll column to the next column to be filled (mod 32).
  assign ahead = write_col - scroll_offset[9:5];

  // Column FSM: next state, handshake and tilemap write request.
  always_comb begin
    state_next  = state;
    row_next    = row;
    col_ready   = 1'b0;
    wr_en       = 1'b0;
    wr_tile     = 8'h00;
    col_advance = 1'b0;
    case (state)
      IDLE: begin
        col_ready = !reset && (ahead < LOOKAHEAD_C);
        if (col_valid && col_ready) begin
          wr_en    = 1'b1;
          wr_tile  = col_tile;
          row_next = 4'd1;
          if (LAST_ROW == 4'd0) begin
            state_next = COMMIT;
          end else if (col_last) begin
            state_next = PAD;
          end else begin
            state_next = STREAM;
          end
        end
      end
      STREAM: begin
        col_ready = !reset;
        if (col_valid && col_ready) begin
          wr_en    = 1'b1;
          wr_tile  = col_tile;
          row_next = row + 4'd1;
          // The final row closes the column whatever col_last says.
          if (row == LAST_ROW) begin
            state_next = COMMIT;
          end else if (col_last) begin
            state_next = PAD;
          end
        end
      end
      PAD: begin
        wr_en    = 1'b1;
        wr_tile  = 8'h00;
        row_next = row + 4'd1;
        if (row == LAST_ROW) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        row_next    = 4'd0;
        col_advance = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state, row/column counters and the registered tilemap write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row        <= 4'd0;
      write_col  <= 5'd0;
      tm_we      <= 1'b0;
      tm_address <= 14'd0;
      tm_din     <= 8'h00;
    end else begin
      state     <= state_next;
      row       <= row_next;
      write_col <= write_col + {4'b0000, col_advance};
      tm_we     <= wr_en;
      if (wr_en) begin
        tm_address <= {4'b0000, row, 1'b0, write_col};
        tm_din     <= wr_tile;
      end
    end
  end

  // Legality of a frame advance, judged against the column count including
  // a commit landing in the same cycle.
  always_comb begin
    wc_after    = write_col + {4'b0000, col_advance};
    scroll_next = scroll_offset + {5'b00000, speed};
    ahead_after = wc_after - scroll_next[9:5];
    advance_ok  = (ahead_after >= MIN_AHEAD);
  end

  // Scroll position and sticky underrun flag, updated once per frame tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      scroll_offset <= 10'd0;
      underrun      <= 1'b0;
    end else if (frame_tick && enable) begin
      if (advance_ok) begin
        scroll_offset <= scroll_next;
      end else begin
        underrun <= 1'b1;
`ifdef TILEMAP_WRITER_STALL_EN
        scroll_offset <= scroll_offset;
`else
        scroll_offset <= scroll_next;
`endif
      end
    end
  end

endmodule
